mdio_dri: RTL and testbench

MDIO bus master that executes single Clause-22 register transactions on the PHY management interface. It accepts one operation at a time on the `op_*` request interface from the MDIO control sequencer, serialises the full frame on MDC/MDIO, and returns completion, acknowledge status and read data on the same interface. It sits between the MDIO control sequencer and the top-level MDIO IOBUF.

---
 rtl/mdio_pkg.sv | 24 ++
 rtl/mdio_dri_mdc_gen.sv | 51 +++++
 rtl/mdio_dri.sv | 141 ++++++++++++++
 tb/tb_mdio_dri.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mdio_pkg.sv
// Shared constants, state encoding and per-state bit lengths for the
// Clause-22 MDIO master.
`timescale 1ns/1ps
package mdio_pkg;

  localparam logic [1:0] MDIO_ST      = 2'b01;
  localparam logic [1:0] MDIO_OP_RD   = 2'b10;
  localparam logic [1:0] MDIO_OP_WR   = 2'b01;
  localparam int         MDIO_PRE_LEN = 32;

  typedef enum logic [2:0] {IDLE, PRE, HDR, TA, DATA, DONE} mdio_state_e;

  // Number of MDC bit periods spent in each frame-carrying state.
  function automatic logic [5:0] state_len(mdio_state_e s);
    case (s)
      PRE:     return 6'(MDIO_PRE_LEN);
      HDR:     return 6'd14;
      TA:      return 6'd2;
      DATA:    return 6'd16;
      default: return 6'd1;
    endcase
  endfunction

endpackage

// File: rtl/mdio_dri_mdc_gen.sv
// MDC divider: low half then high half, each CLK_DIV cycles. Strobes flag
// the cycle whose closing edge makes MDC fall or rise.
`timescale 1ns/1ps
module mdc_gen #(
  parameter int CLK_DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic restart_i,
  output logic eth_mdc,
  output logic fall_stb,
  output logic rise_stb
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] div_q, div_d;
  logic          mdc_q, mdc_d;
  logic          last;

  assign last     = (div_q == CW'(CLK_DIV - 1));
  assign rise_stb = en_i && last && !mdc_q;
  assign fall_stb = en_i && last && mdc_q;
  assign eth_mdc  = mdc_q;

  always_comb begin
    div_d = div_q;
    mdc_d = mdc_q;
    if (restart_i || !en_i) begin
      div_d = '0;
      mdc_d = 1'b0;
    end else if (last) begin
      div_d = '0;
      mdc_d = ~mdc_q;
    end else begin
      div_d = div_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      div_q <= '0;
      mdc_q <= 1'b0;
    end else begin
      div_q <= div_d;
      mdc_q <= mdc_d;
    end
  end

endmodule

// File: rtl/mdio_dri.sv
// Clause-22 MDIO master: one read or write frame per accepted request,
// returning acknowledge and read data with a one-cycle done pulse.
`timescale 1ns/1ps
module mdio_dri
  import mdio_pkg::*;
#(
  parameter logic [4:0] PHY_ADDR = 5'b00111,
  parameter int         CLK_DIV  = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_exec,
  input  logic        op_rh_wl,
  input  logic [4:0]  op_addr,
  input  logic [15:0] op_wr_data,
  output logic        op_done,
  output logic        op_rd_ack,
  output logic [15:0] op_rd_data,
  output logic        busy,
  output logic        eth_mdc,
  output logic        eth_mdio_o,
  output logic        eth_mdio_oe,
  input  logic        eth_mdio_i
);

  mdio_state_e state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        rd_q, rd_d;
  logic [31:0] tx_q, tx_d;
  logic [15:0] rx_q, rx_d;
  logic        ack_q, ack_d;
  logic        rd_ack_q, rd_ack_d;
  logic [15:0] rd_data_q, rd_data_d;
  logic        mdio_o_q, mdio_o_d;
  logic        oe_q, oe_d;
  logic        accept, fall_stb, rise_stb, mdc_en;

  assign mdc_en = (state_q == PRE) || (state_q == HDR) || (state_q == TA) || (state_q == DATA);

  mdc_gen #(.CLK_DIV(CLK_DIV)) u_mdc (
    .clk       (clk),
    .rst       (rst),
    .en_i      (mdc_en),
    .restart_i (accept),
    .eth_mdc   (eth_mdc),
    .fall_stb  (fall_stb),
    .rise_stb  (rise_stb)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_d      = rd_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    ack_d     = ack_q;
    rd_ack_d  = rd_ack_q;
    rd_data_d = rd_data_q;
    mdio_o_d  = mdio_o_q;
    oe_d      = oe_q;
    accept    = 1'b0;
    case (state_q)
      IDLE: begin
        if (op_exec) begin
          accept   = 1'b1;
          state_d  = PRE;
          cnt_d    = '0;
          rd_d     = op_rh_wl;
          tx_d     = {MDIO_ST, op_rh_wl ? MDIO_OP_RD : MDIO_OP_WR, PHY_ADDR, op_addr, 2'b10, op_wr_data};
          mdio_o_d = 1'b1;
          oe_d     = 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: begin
        if (rise_stb) begin
          if (state_q == TA && cnt_q == 6'd1) ack_d = eth_mdio_i;
          if (state_q == DATA) rx_d = {rx_q[14:0], eth_mdio_i};
        end
        if (fall_stb) begin
          if (cnt_q == state_len(state_q) - 6'd1) begin
            cnt_d = '0;
            case (state_q)
              PRE:     state_d = HDR;
              HDR:     state_d = TA;
              TA:      state_d = DATA;
              default: state_d = DONE;
            endcase
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
          // Launch the next bit together with the falling MDC edge.
          if (state_d == DONE) begin
            mdio_o_d = 1'b1;
            oe_d     = 1'b0;
            rd_ack_d = rd_q ? ack_q : 1'b0;
            if (rd_q) rd_data_d = rx_q;
          end else if (state_d != PRE) begin
            oe_d     = (state_d == HDR) || !rd_q;
            mdio_o_d = oe_d ? tx_q[31] : 1'b1;
            tx_d     = {tx_q[30:0], 1'b0};
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rd_q      <= 1'b0;
      tx_q      <= '0;
      rx_q      <= '0;
      ack_q     <= 1'b0;
      rd_ack_q  <= 1'b0;
      rd_data_q <= '0;
      mdio_o_q  <= 1'b1;
      oe_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_q      <= rd_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      ack_q     <= ack_d;
      rd_ack_q  <= rd_ack_d;
      rd_data_q <= rd_data_d;
      mdio_o_q  <= mdio_o_d;
      oe_q      <= oe_d;
    end
  end

  assign op_done     = (state_q == DONE);
  assign busy        = (state_q != IDLE);
  assign op_rd_ack   = rd_ack_q;
  assign op_rd_data  = rd_data_q;
  assign eth_mdio_o  = mdio_o_q;
  assign eth_mdio_oe = oe_q;

endmodule

// File: tb/tb_mdio_dri.sv
// Bench for mdio_dri: PHY model on a pulled-up line, a register-file
// reference model, and directed plus randomized register transactions.
`timescale 1ns/1ps
module tb_mdio_dri;

  localparam int         CLK_DIV = 2;
  localparam logic [4:0] PHY     = 5'b00111;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        op_exec = 1'b0;
  logic        op_rh_wl = 1'b0;
  logic [4:0]  op_addr = '0;
  logic [15:0] op_wr_data = '0;
  logic        op_done, op_rd_ack, busy, eth_mdc, eth_mdio_o, eth_mdio_oe, eth_mdio_i;
  logic [15:0] op_rd_data;

  always #5 clk = ~clk;

  mdio_dri #(.PHY_ADDR(PHY), .CLK_DIV(CLK_DIV)) dut (
    .clk         (clk),
    .rst         (rst),
    .op_exec     (op_exec),
    .op_rh_wl    (op_rh_wl),
    .op_addr     (op_addr),
    .op_wr_data  (op_wr_data),
    .op_done     (op_done),
    .op_rd_ack   (op_rd_ack),
    .op_rd_data  (op_rd_data),
    .busy        (busy),
    .eth_mdc     (eth_mdc),
    .eth_mdio_o  (eth_mdio_o),
    .eth_mdio_oe (eth_mdio_oe),
    .eth_mdio_i  (eth_mdio_i)
  );

  // Pad: master drives when enabled, else PHY, else pull-up.
  logic phy_oe, phy_o;
  assign eth_mdio_i = eth_mdio_oe ? eth_mdio_o : (phy_oe ? phy_o : 1'b1);

  logic        clr_req = 1'b0;
  bit          phy_present = 1'b1;
  logic [15:0] phy_regs [32];
  logic        cap [$];
  logic        capoe [$];

  initial begin : phy_bfm
    int          k;
    logic [63:0] sh;
    logic [15:0] v;
    logic [4:0]  ra;
    bit          resp;
    for (int i = 0; i < 32; i++) phy_regs[i] = 16'($urandom);
    phy_regs[2] = 16'h0141;
    phy_oe = 1'b0; phy_o = 1'b1; k = 0; sh = '0; resp = 1'b0; ra = '0;
    forever begin
      @(posedge eth_mdc or posedge clr_req);
      if (clr_req) begin
        k = 0; sh = '0; resp = 1'b0; phy_oe = 1'b0; phy_o = 1'b1;
        cap.delete(); capoe.delete();
      end else begin
        cap.push_back(eth_mdio_i);
        capoe.push_back(eth_mdio_oe);
        sh = {sh[62:0], eth_mdio_i};
        if (k == 45) begin
          resp = phy_present && sh[13:12] == 2'b01 && sh[11:10] == 2'b10 && sh[9:5] == PHY;
          ra   = sh[4:0];
        end
        if (k == 63 && phy_present && sh[31:30] == 2'b01 && sh[29:28] == 2'b01 && sh[27:23] == PHY)
          phy_regs[sh[22:18]] = sh[15:0];
        #2;
        if (resp) begin
          if (k == 46) begin
            phy_oe = 1'b1; phy_o = 1'b0;
          end else if (k >= 47 && k <= 62) begin
            v = phy_regs[ra]; phy_o = v[62 - k];
          end else if (k == 63) begin
            phy_oe = 1'b0; phy_o = 1'b1; resp = 1'b0;
          end
        end
        k++;
      end
    end
  end

  int          checks = 0;
  int          errors = 0;
  logic [15:0] mdl_regs [32];
  logic [15:0] mdl_rd_data;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_op(input bit rd, input logic [4:0] addr, input logic [15:0] wdata,
                       input bit junk_mid, input bit junk_done, input int abort_n);
    int          n, dones;
    bit          got;
    logic [63:0] capv, oev, exp_frame, exp_oe;
    logic [16:0] exp_rd;
    exp_frame = {32'hFFFF_FFFF, 2'b01, rd ? 2'b10 : 2'b01, PHY, addr, 2'b10, wdata};
    exp_oe    = rd ? ({64{1'b1}} << 18) : {64{1'b1}};
    if (rd) exp_rd = phy_present ? {1'b0, mdl_regs[addr]} : {1'b1, 16'hFFFF};
    else    exp_rd = {1'b0, mdl_rd_data};
    op_exec = 1'b1; op_rh_wl = rd; op_addr = addr; op_wr_data = wdata; clr_req = 1'b1;
    n = 0; got = 1'b0;
    while (!got && n < 400) begin
      @(negedge clk);
      n++;
      op_exec = 1'b0; clr_req = 1'b0;
      if (n == 1) check("busy_after_accept", 64'(busy), 64'd1);
      if (junk_mid && n == 100) begin
        op_exec = 1'b1; op_rh_wl = ~rd; op_addr = addr ^ 5'h1F;
      end
      if (abort_n != 0 && n == abort_n) begin
        rst = 1'b0;
        @(negedge clk);
        check("abort_mdc", 64'(eth_mdc), 64'd0);
        check("abort_oe", 64'(eth_mdio_oe), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(op_done), 64'd0);
        rst = 1'b1;
        mdl_rd_data = '0;
        dones = 0;
        for (int i = 0; i < 300; i++) begin
          @(negedge clk);
          if (op_done === 1'b1) dones++;
        end
        check("no_done_after_abort", 64'(dones), 64'd0);
        $display("txn abort rd=%0d addr=%0d at cycle %0d", rd, addr, n);
        return;
      end
      if (op_done === 1'b1) got = 1'b1;
    end
    check("done_latency", 64'(n), 64'd257);
    check("rd_ack", 64'(op_rd_ack), 64'(exp_rd[16]));
    check("rd_data", 64'(op_rd_data), 64'(exp_rd[15:0]));
    check("oe_in_done", 64'(eth_mdio_oe), 64'd0);
    check("frame_len", 64'(cap.size()), 64'd64);
    capv = '0; oev = '0;
    foreach (cap[i])   capv = {capv[62:0], cap[i]};
    foreach (capoe[i]) oev  = {oev[62:0], capoe[i]};
    check("frame_bits", capv & exp_oe, exp_frame & exp_oe);
    check("oe_pattern", oev, exp_oe);
    if (rd) mdl_rd_data = exp_rd[15:0];
    else if (phy_present) mdl_regs[addr] = wdata;
    $display("txn %s addr=%0d wdata=%04h phy=%0d -> ack=%0d data=%04h latency=%0d",
             rd ? "RD" : "WR", addr, wdata, phy_present, op_rd_ack, op_rd_data, n);
    if (junk_done) begin
      op_exec = 1'b1; op_rh_wl = 1'b1; op_addr = 5'd3;
      @(negedge clk);
      op_exec = 1'b0;
      check("late_exec_ignored", 64'(busy), 64'd0);
      check("single_done", 64'(op_done), 64'd0);
    end
  endtask

  initial begin
    bit          rd;
    logic [4:0]  a;
    logic [15:0] d;
    mdl_rd_data = '0;
    repeat (3) @(negedge clk);
    check("rst_done", 64'(op_done), 64'd0);
    check("rst_ack", 64'(op_rd_ack), 64'd0);
    check("rst_data", 64'(op_rd_data), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_mdc", 64'(eth_mdc), 64'd0);
    check("rst_mdio_o", 64'(eth_mdio_o), 64'd1);
    check("rst_oe", 64'(eth_mdio_oe), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 32; i++) mdl_regs[i] = phy_regs[i];

    do_op(1'b0, 5'd0, 16'h8140, 1'b0, 1'b0, 0);
    @(negedge clk);
    do_op(1'b1, 5'd2, 16'h0000, 1'b0, 1'b0, 0);
    check("rd_reg2_value", 64'(op_rd_data), 64'h0141);
    @(negedge clk);
    phy_present = 1'b0;
    do_op(1'b1, 5'd17, 16'h0000, 1'b0, 1'b0, 0);
    phy_present = 1'b1;
    @(negedge clk);
    do_op(1'b0, 5'd5, 16'($urandom), 1'b1, 1'b1, 0);
    do_op(1'b1, 5'd5, 16'h0000, 1'b0, 1'b0, 0);
    @(negedge clk);
    do_op(1'b1, 5'd9, 16'h0000, 1'b0, 1'b0, 210);
    @(negedge clk);
    do_op(1'b1, 5'd1, 16'h0000, 1'b0, 1'b0, 0);
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      rd = 1'($urandom_range(0, 1));
      a  = 5'($urandom_range(0, 31));
      d  = 16'($urandom);
      phy_present = ($urandom_range(0, 3) != 0);
      do_op(rd, a, d, 1'b0, 1'b0, 0);
    end
    phy_present = 1'b1;
    @(negedge clk);
    do_op(1'b1, 5'd0, 16'h0000, 1'b0, 1'b0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
